// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// geometry, PC field widths and controller state encoding.
package icache_pkg;

    localparam int unsigned NUM_BLOCKS      = 8;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned ADDR_BITS       = 10;

    localparam int unsigned TAG_W   = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned BLK_A_W = TAG_W + IDX_W;
    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Miss/fill controller: detects a miss in IDLE, runs the MEM_READ handshake
// for the latched block address, then strobes one array write in UPDATE.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               hit,
    input  logic [BLK_A_W-1:0] pc_block,
    input  logic               MEM_BUSYWAIT,
    output logic               MEM_READ,
    output logic [BLK_A_W-1:0] MEM_ADDRESS,
    output logic [BLK_A_W-1:0] miss_addr,
    output logic               busy,
    output logic               capture_en,
    output logic               write_en
);

    state_t state;
    state_t state_next;
    logic   first_cycle;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= '0;
            miss_addr   <= '0;
            first_cycle <= 1'b0;
        end else begin
            state       <= state_next;
            first_cycle <= 1'b0;
            if (state == ST_IDLE && !hit) begin
                miss_addr   <= pc_block;
                MEM_ADDRESS <= pc_block;
                MEM_READ    <= 1'b1;
                first_cycle <= 1'b1;
            end
            if (capture_en) begin
                MEM_READ <= 1'b0;
            end
        end
    end

    // The first MEM_READ cycle ignores MEM_BUSYWAIT: memory has not yet raised it.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        capture_en = 1'b0;
        write_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = !hit;
                if (!hit) begin
                    state_next = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                if (!first_cycle && !MEM_BUSYWAIT) begin
                    capture_en = 1'b1;
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                write_en   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: 8 lines of 4 words, 0-cycle hit,
// block fill from slow instruction memory on a miss.
module instr_cache
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        PC,
    output logic [31:0]        INSTRUCTION,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic [5:0]         MEM_ADDRESS,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_arr [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    fill_buf;

    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [BLK_A_W-1:0] pc_block;
    logic [BLK_A_W-1:0] miss_addr;
    logic [IDX_W-1:0]   miss_idx;
    logic               hit;
    logic               busy;
    logic               capture_en;
    logic               write_en;
    logic               unused_pc_bits;

    assign pc_off         = PC[3:2];
    assign pc_idx         = PC[6:4];
    assign pc_tag         = PC[9:7];
    assign pc_block       = PC[9:4];
    assign miss_idx       = miss_addr[IDX_W-1:0];
    assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

    assign hit         = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign BUSYWAIT    = !RESET && busy;
    assign INSTRUCTION = RESET ? '0 : data_arr[pc_idx][{pc_off, 5'b00000} +: 32];

    icache_ctrl u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .hit          (hit),
        .pc_block     (pc_block),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .miss_addr    (miss_addr),
        .busy         (busy),
        .capture_en   (capture_en),
        .write_en     (write_en)
    );

    always_ff @(posedge CLK) begin
        if (capture_en) begin
            fill_buf <= MEM_READDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
        end else if (write_en) begin
            valid[miss_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; gating on RESET aborts a fill caught mid-UPDATE.
    always_ff @(posedge CLK) begin
        if (!RESET && write_en) begin
            tag_arr[miss_idx]  <= miss_addr[BLK_A_W-1:IDX_W];
            data_arr[miss_idx] <= fill_buf;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: behavioural slow memory plus a
// scoreboard of expected fetch results.
module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  PC = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b0;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    logic [31:0]  exp_q[$];

    int unsigned  mem_latency = 4;
    bit           mem_glitch  = 1'b0;
    int unsigned  mem_cnt     = 0;

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory image: every word holds its own 10-bit byte address.
    function automatic logic [127:0] blk_data(input logic [5:0] a);
        logic [127:0] r;
        logic [1:0]   wl;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            wl = 2'(w);
            r[w*32 +: 32] = {22'b0, a, wl, 2'b00};
        end
        return r;
    endfunction

    // Optional glitch: a spurious low (with garbage data) in the first request cycle.
    always @(negedge CLK) begin
        if (MEM_READ) begin
            if (mem_cnt == 0 && mem_glitch) begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = ~blk_data(MEM_ADDRESS);
            end else if (mem_cnt < (mem_glitch ? 1 : 0) + mem_latency) begin
                MEM_BUSYWAIT = 1'b1;
            end else begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = blk_data(MEM_ADDRESS);
            end
            mem_cnt++;
        end else begin
            MEM_BUSYWAIT = 1'b0;
            mem_cnt      = 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns once the fetch result has been compared.
    task automatic fetch(input logic [31:0] pc, input bit exp_miss, input logic [5:0] exp_maddr);
        int unsigned cyc;
        int unsigned first_low;
        int unsigned mem_cyc;
        logic [31:0] exp;
        PC = pc;
        exp_q.push_back({22'b0, pc[9:2], 2'b00});
        #1;
        check_val("miss", 32'(BUSYWAIT), 32'(exp_miss));
        if (BUSYWAIT) begin
            cyc       = 1;
            first_low = mem_glitch ? mem_latency + 1 : mem_latency;
            mem_cyc   = ((first_low < 1) ? 1 : first_low) + 1;
            for (int i = 0; i < 60 && BUSYWAIT; i++) begin
                @(negedge CLK);
                #1;
                if (i == 0) begin
                    check_val("mem_read", 32'(MEM_READ), 32'd1);
                    check_val("mem_addr", 32'(MEM_ADDRESS), 32'(exp_maddr));
                end
                if (BUSYWAIT) cyc++;
            end
            check_val("penalty", cyc, mem_cyc + 2);
        end else begin
            check_val("no_mem_read", 32'(MEM_READ), 32'd0);
        end
        exp = exp_q.pop_front();
        check_val("instr", INSTRUCTION, exp);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        check_val("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check_val("rst_instr", INSTRUCTION, 32'd0);
        check_val("rst_mem_read", 32'(MEM_READ), 32'd0);
        check_val("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);

        @(negedge CLK);
        RESET = 1'b0;
        mem_latency = 4;
        fetch(32'h000, 1'b1, 6'd0);
        @(negedge CLK); fetch(32'h004, 1'b0, 6'd0);
        @(negedge CLK); fetch(32'h008, 1'b0, 6'd0);
        @(negedge CLK); fetch(32'h00C, 1'b0, 6'd0);
        @(negedge CLK); fetch(32'h400, 1'b0, 6'd0);
        @(negedge CLK); fetch(32'h404, 1'b0, 6'd0);

        mem_latency = 1;
        @(negedge CLK); fetch(32'h080, 1'b1, 6'd8);
        @(negedge CLK); fetch(32'h084, 1'b0, 6'd0);
        @(negedge CLK); fetch(32'h000, 1'b1, 6'd0);

        @(negedge CLK);
        mem_glitch  = 1'b1;
        mem_latency = 3;
        fetch(32'h3FC, 1'b1, 6'd63);
        mem_glitch = 1'b0;
        @(negedge CLK); fetch(32'h3F0, 1'b0, 6'd0);

        @(negedge CLK);
        mem_latency = 6;
        PC = 32'h040;
        #1;
        check_val("midfill_miss", 32'(BUSYWAIT), 32'd1);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_val("midfill_rst_busywait", 32'(BUSYWAIT), 32'd0);
        check_val("midfill_rst_instr", INSTRUCTION, 32'd0);
        @(posedge CLK);
        #1;
        check_val("midfill_rst_mem_read", 32'(MEM_READ), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        mem_latency = 2;
        fetch(32'h004, 1'b1, 6'd0);
        mem_latency = 0;
        @(negedge CLK); fetch(32'h3FC, 1'b1, 6'd63);
        @(negedge CLK); fetch(32'h008, 1'b0, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
